// File: rtl/rgb565_ahb_writer.sv
// Packs RGB565 pixel pairs into 32-bit words and writes them to the frame buffer as an AHB-Lite master.
// A word reaches the FIFO on the edge of its second pixel; the FIFO absorbs bus stalls and drops words when full.

module sync_fifo #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic [WIDTH-1:0] push_dat,
   input  logic             pop,
   output logic [WIDTH-1:0] head,
   output logic             full,
   output logic             empty
);
   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign empty   = (wr_ptr == rd_ptr);
   assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign do_pop  = pop && !empty;
   // a full FIFO still takes a push when the head leaves on the same edge
   assign do_push = push && (!full || do_pop);
   assign head    = mem[rd_ptr[AW-1:0]];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr[AW-1:0]] <= push_dat;
   end
endmodule

module rgb565_ahb_writer #(
   parameter logic [31:0] BASE_ADDR  = 32'h2000_0000,
   parameter int          FIFO_DEPTH = 16
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [15:0] pix_in,
   input  logic        pix_en,
   input  logic        frame_end,
   output logic [31:0] HADDR,
   output logic [1:0]  HTRANS,
   output logic        HWRITE,
   output logic [2:0]  HSIZE,
   output logic [2:0]  HBURST,
   output logic [31:0] HWDATA,
   input  logic        HREADY,
   input  logic        HRESP,
   output logic        busy,
   output logic        overflow,
   output logic        bus_err,
   output logic        frame_done
);
   localparam logic [1:0] TR_IDLE   = 2'b00;
   localparam logic [1:0] TR_NONSEQ = 2'b10;

   typedef enum logic [1:0] {ST_IDLE, ST_ADDR, ST_DATA} state_t;

   state_t      state;
   state_t      state_nxt;
   logic        half;
   logic [15:0] pend;
   logic        push;
   logic [31:0] push_dat;
   logic        pop;
   logic        load_wdata;
   logic        fifo_full;
   logic        fifo_empty;
   logic [31:0] fifo_head;
   logic [31:0] wr_addr;
   logic        flush_req;
   logic        done_cond;

   // An odd pixel is flushed on frame_end, whether pending or arriving that cycle
   always_comb begin
      push     = 1'b0;
      push_dat = {16'h0000, pend};
      if (pix_en && half) begin
         push     = 1'b1;
         push_dat = {pix_in, pend};
      end else if (frame_end && pix_en) begin
         push     = 1'b1;
         push_dat = {16'h0000, pix_in};
      end else if (frame_end && half) begin
         push     = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         half <= 1'b0;
         pend <= 16'h0000;
      end else begin
         if (pix_en && !half) pend <= pix_in;
         if (frame_end)       half <= 1'b0;
         else if (pix_en)     half <= !half;
      end
   end

   sync_fifo #(
      .WIDTH (32),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk      (clk),
      .rst_n    (rst_n),
      .push     (push),
      .push_dat (push_dat),
      .pop      (pop),
      .head     (fifo_head),
      .full     (fifo_full),
      .empty    (fifo_empty)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= ST_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: if (!fifo_empty) state_nxt = ST_ADDR;
         ST_ADDR: if (HREADY)      state_nxt = ST_DATA;
         ST_DATA: if (HREADY)      state_nxt = ST_IDLE;
         default:                  state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      HTRANS     = (state == ST_ADDR) ? TR_NONSEQ : TR_IDLE;
      load_wdata = (state == ST_ADDR) && HREADY;
      pop        = (state == ST_DATA) && HREADY;
   end

   assign done_cond = flush_req && fifo_empty && (state == ST_IDLE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         HWDATA     <= 32'h0000_0000;
         wr_addr    <= BASE_ADDR;
         flush_req  <= 1'b0;
         frame_done <= 1'b0;
         overflow   <= 1'b0;
         bus_err    <= 1'b0;
      end else begin
         frame_done <= done_cond;
         if (load_wdata) HWDATA <= fifo_head;
         if (done_cond)  wr_addr <= BASE_ADDR;
         else if (pop)   wr_addr <= wr_addr + 32'd4;
         if (frame_end)      flush_req <= 1'b1;
         else if (done_cond) flush_req <= 1'b0;
         if (push && fifo_full && !pop)      overflow <= 1'b1;
         if ((state == ST_DATA) && HRESP)    bus_err  <= 1'b1;
      end
   end

   assign HADDR  = wr_addr;
   assign HWRITE = 1'b1;
   assign HSIZE  = 3'b010;
   assign HBURST = 3'b000;
   assign busy   = !fifo_empty || (state != ST_IDLE);
endmodule
